lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load-store unit on the consuming end of the decoder's `mem_wren`/`ls_op` control. It turns one core memory request into one or two word-aligned data-memory transactions over a req/ack handshake.
- Applies byte enables on stores; extracts, merges and sign/zero-extends load data.
- Stalls the core until the transaction completes.
- Sits between the execute stage and data memory.

Parameters:
- SPLIT_MISALIGNED, 1, 1: a word-crossing access is split into two transactions; 0: a crossing access completes with err_o and no memory access.
- ACK_TIMEOUT, 16, maximum wait cycles per transaction for mem_ack_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, single domain
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  core request valid
- we_i  in  1  1 = store, 0 = load (decoder mem_wren)
- ls_op_i  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  byte address (ALU result)
- st_data_i  in  32  store data, right-aligned
- stall_o  out  1  freeze core pipeline
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o: illegal op, disallowed misalign, or timeout
- ld_data_o  out  32  extended load result, valid with done_o
- mem_req_o  out  1  memory transaction request
- mem_we_o  out  1  memory write
- mem_addr_o  out  32  word address, bits [1:0] = 00
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-shifted write data
- mem_ack_i  in  1  transaction complete; mem_rdata_i valid this cycle
- mem_rdata_i  in  32  read word

Behaviour:
- Reset: state IDLE. All outputs 0, counter 0. Reset mid-transaction drops mem_req_o immediately; no done_o follows.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE + req_i: capture we, op, addr, data.
  - Size n = 1/2/4 from op[1:0]; off = addr[1:0].
  - Illegal op (011, 110, 111, or store with op[2] = 1): go to DONE with err.
  - off + n > 4 and SPLIT_MISALIGNED = 0: go to DONE with err.
  - Otherwise go to ACC0.
- ACC0:
  - mem_req_o = 1, mem_addr_o = {addr[31:2], 2'b00}.
  - mem_be_o = (mask_n << off)[3:0], where mask_n = 1/3/F.
  - mem_wdata_o = st_data << 8*off.
  - On ack: latch rdata0. Go to ACC1 if off + n > 4, else DONE.
- ACC1:
  - mem_addr_o = word address + 4 (wraps modulo 2^32).
  - mem_be_o = (mask_n << off)[7:4].
  - mem_wdata_o = st_data >> 8*(4 - off).
  - On ack: latch rdata1, go to DONE.
- Request hold: mem_req_o and all mem_* outputs are held stable until ack. A new transaction never starts in the ack cycle.
- Load data: {rdata1, rdata0} >> 8*off; take the low n bytes. Sign-extend for B/H, zero-extend for BU/HU.
- Timeout: counter counts cycles in ACC0/ACC1 without ack and clears on state change. When it reaches ACK_TIMEOUT: drop the request and go to DONE with err.
- DONE:
  - done_o = 1 for exactly one cycle, then IDLE.
  - err_o = 1 only on error; on error ld_data_o = 0.
  - req_i in DONE is ignored; the core re-presents it in IDLE.
- Stores: ld_data_o = 0.
- stall_o = (IDLE & req_i) | ACC0 | ACC1. stall_o is 0 in DONE.
- Minimum latency: aligned access with same-cycle ack is accept T0, ACC0 T1, done_o T2.

Decomposition:
- lsu_pkg:
  - ls_op localparams (LS_B, LS_H, LS_W, LS_BU, LS_HU).
  - state enum.
  - size/mask functions.
- Sub-module lsu_align (combinational): produces be/wdata lane shift and load merge/extend from off, n, op.

Test Plan:
- Aligned LW at 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> mem_addr 0x100, be F, done_o at T4, ld_data 0xDEADBEEF, err 0.
- LB at 0x103, rdata 0x80xxxxxx -> be 8, ld_data 0xFFFFFF80; same access as LBU -> 0x00000080.
- SH at 0x203, data 0xABCD -> ACC0 addr 0x200, be 8, wdata[31:24] = 0xCD; ACC1 addr 0x204, be 1, wdata[7:0] = 0xAB; done_o once.
- LW at 0x002 with rdata0 0x11223344, rdata1 0x55667788 -> ld_data 0x77881122. With SPLIT_MISALIGNED = 0 -> err_o, mem_req_o never asserted.
- No ack for 16 cycles -> mem_req_o drops, done_o & err_o. ls_op 011 -> done_o & err_o one cycle after accept.
- rst_ni low during ACC0 -> mem_req_o, stall_o = 0 immediately; no done_o after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: funct3 size codes, FSM state
// encoding and small helpers that turn a size code into a byte count or a
// byte-lane mask.
package lsu_pkg;

    // funct3 size codes as seen on ls_op
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Byte count of an access; 0 marks a code that is not a legal size.
    function automatic logic [2:0] ls_size(input logic [2:0] op);
        case (op)
            LS_B, LS_BU: ls_size = 3'd1;
            LS_H, LS_HU: ls_size = 3'd2;
            LS_W:        ls_size = 3'd4;
            default:     ls_size = 3'd0;
        endcase
    endfunction

    // Unshifted byte-lane mask for an access of the given size.
    function automatic logic [3:0] ls_mask(input logic [2:0] op);
        case (op)
            LS_B, LS_BU: ls_mask = 4'h1;
            LS_H, LS_HU: ls_mask = 4'h3;
            LS_W:        ls_mask = 4'hF;
            default:     ls_mask = 4'h0;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic ls_illegal(input logic we, input logic [2:0] op);
        ls_illegal = (ls_size(op) == 3'd0) || (we && op[2]);
    endfunction

    // True when the access spills past the end of its 32-bit word.
    function automatic logic ls_cross(input logic [1:0] off, input logic [2:0] size);
        ls_cross = ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load-store unit (purely combinational).
//   off      : byte offset of the access within its word
//   op       : funct3 size code
//   hi       : 0 = first (lower) word of the access, 1 = second word
//   st_data  : right-aligned store data
//   rdata0/1 : read words of the first and second transaction
//   be       : byte enables for the word selected by hi
//   wdata    : lane-shifted write data for the word selected by hi
//   ld_data  : merged, shifted and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    input  logic        hi,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    // Work on an 8-lane / 64-bit view of the two words so that the split
    // case falls out of a single shift; the upper half feeds the second word.
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_wide;

    always_comb begin
        be_wide = {4'b0000, ls_mask(op)} << off;
        wd_wide = {32'h0000_0000, st_data} << {off, 3'b000};
        rd_wide = {rdata1, rdata0} >> {off, 3'b000};

        be    = hi ? be_wide[7:4] : be_wide[3:0];
        wdata = hi ? wd_wide[63:32] : wd_wide[31:0];

        case (op)
            LS_B:    ld_data = {{24{rd_wide[7]}}, rd_wide[7:0]};
            LS_H:    ld_data = {{16{rd_wide[15]}}, rd_wide[15:0]};
            LS_BU:   ld_data = {24'h000000, rd_wide[7:0]};
            LS_HU:   ld_data = {16'h0000, rd_wide[15:0]};
            default: ld_data = rd_wide[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load-store unit controller. Turns one core memory request into one or two
// word-aligned memory transactions over a req/ack handshake and stalls the
// core until the access completes.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   req_i, we_i, ls_op_i,
//   addr_i, st_data_i         : core request (held by the core while stalled)
//   stall_o                   : freeze the core pipeline
//   done_o, err_o, ld_data_o  : one-cycle completion pulse with status/result
//   mem_req_o .. mem_wdata_o  : data-memory transaction, held until mem_ack_i
//   mem_ack_i, mem_rdata_i    : transaction complete, read word
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit          SPLIT_MISALIGNED = 1'b1,
    parameter int unsigned ACK_TIMEOUT      = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  ls_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] ld_data_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lsu_state_e       state_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic        we_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        in_acc;
    logic        cross_q;
    logic        timeout;
    logic        start_bad;
    logic [31:0] word_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld;

    assign in_acc    = (state_q == ST_ACC0) || (state_q == ST_ACC1);
    assign cross_q   = ls_cross(addr_q[1:0], ls_size(op_q));
    // An ACK_TIMEOUT of 0 disables the watchdog entirely.
    assign timeout   = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign start_bad = ls_illegal(we_i, ls_op_i) ||
                       (!SPLIT_MISALIGNED && ls_cross(addr_i[1:0], ls_size(ls_op_i)));
    assign word_addr = {addr_q[31:2], 2'b00};

    // Control path: state, error flag and ack watchdog.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req_i) begin
                        err_q   <= start_bad;
                        state_q <= start_bad ? ST_DONE : ST_ACC0;
                    end
                end
                ST_ACC0, ST_ACC1: begin
                    if (mem_ack_i) begin
                        cnt_q   <= '0;
                        state_q <= (state_q == ST_ACC0 && cross_q) ? ST_ACC1 : ST_DONE;
                    end else if (timeout) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Data path: request capture and read-word latches; only ever consumed
    // under state qualification, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_IDLE && req_i) begin
            we_q   <= we_i;
            op_q   <= ls_op_i;
            addr_q <= addr_i;
            data_q <= st_data_i;
        end
        if (state_q == ST_ACC0 && mem_ack_i) begin
            rdata0_q <= mem_rdata_i;
        end
        if (state_q == ST_ACC1 && mem_ack_i) begin
            rdata1_q <= mem_rdata_i;
        end
    end

    lsu_align u_align (
        .off     (addr_q[1:0]),
        .op      (op_q),
        .hi      (state_q == ST_ACC1),
        .st_data (data_q),
        .rdata0  (rdata0_q),
        .rdata1  (rdata1_q),
        .be      (al_be),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    // Memory-side outputs depend only on registered state, so they stay
    // stable for the whole wait and are forced to zero outside an access.
    always_comb begin
        mem_req_o   = in_acc;
        mem_we_o    = in_acc && we_q;
        mem_addr_o  = 32'h0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (in_acc) begin
            // Second word wraps modulo 2^32 by plain 32-bit addition.
            mem_addr_o  = (state_q == ST_ACC1) ? word_addr + 32'd4 : word_addr;
            mem_be_o    = al_be;
            mem_wdata_o = al_wdata;
        end
    end

    assign stall_o   = ((state_q == ST_IDLE) && req_i) || in_acc;
    assign done_o    = (state_q == ST_DONE);
    assign err_o     = (state_q == ST_DONE) && err_q;
    assign ld_data_o = ((state_q == ST_DONE) && !err_q && !we_q) ? al_ld : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req2;
    logic        we;
    logic [2:0]  ls_op;
    logic [31:0] addr, st_data;
    logic        stall, done, err;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        stall2, done2, err2, mem_req2, mem_we2, ack2;
    logic [31:0] ld_data2, mem_addr2, mem_wdata2;
    logic [3:0]  mem_be2;

    always #5 clk = ~clk;

    lsu_ctrl #(.SPLIT_MISALIGNED(1'b1), .ACK_TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .ls_op_i(ls_op),
        .addr_i(addr), .st_data_i(st_data), .stall_o(stall), .done_o(done),
        .err_o(err), .ld_data_o(ld_data), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    lsu_ctrl #(.SPLIT_MISALIGNED(1'b0), .ACK_TIMEOUT(16)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .we_i(we), .ls_op_i(ls_op),
        .addr_i(addr), .st_data_i(st_data), .stall_o(stall2), .done_o(done2),
        .err_o(err2), .ld_data_o(ld_data2), .mem_req_o(mem_req2), .mem_we_o(mem_we2),
        .mem_addr_o(mem_addr2), .mem_be_o(mem_be2), .mem_wdata_o(mem_wdata2),
        .mem_ack_i(ack2), .mem_rdata_i(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // ---------------- memory images ----------------
    logic [31:0] dmem [logic [31:0]];   // word-organised image seen by the DUT
    logic [7:0]  rmem [logic [31:0]];   // byte-organised image for the model

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[3:0], a[7:4]} ^ 8'h5A ^ a[31:24];
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        logic [31:0] w;
        if (dmem.exists(wa)) return dmem[wa];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(wa + 32'(i));
        return w;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_byte(a);
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        dmem[wa] = w;
        for (int i = 0; i < 4; i++) rmem[wa + 32'(i)] = w[8*i +: 8];
    endtask

    // Reference: a byte-addressed view of the request.
    task automatic ref_access(input logic w, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] ld,
                              output logic e, output int ntx);
        int n;
        logic [31:0] v;
        n  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : (op[1:0] == 2'd2) ? 4 : 0;
        ld = 32'h0; e = 1'b0; ntx = 0;
        if (n == 0 || op == 3'b110 || (w && op[2])) begin
            e = 1'b1;
            return;
        end
        ntx = ((int'(a[1:0]) + n) > 4) ? 2 : 1;
        if (w) begin
            for (int i = 0; i < n; i++) rmem[a + 32'(i)] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | ({24'h0, rd_byte(a + 32'(i))} << (8*i));
            if (n < 4 && !op[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            ld = v;
        end
    endtask

    // ---------------- memory responder ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } tx_t;

    tx_t txq[$];
    int  lat = 0;
    int  wcnt = 0;
    int  hold_err = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] h_addr, h_wd;
    logic [3:0]  h_be;
    logic        h_we;

    initial begin
        logic [31:0] w;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
                if (prev_wait && (mem_addr !== h_addr || mem_be !== h_be ||
                                  mem_wdata !== h_wd || mem_we !== h_we))
                    hold_err++;
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_word(mem_addr);
                    if (mem_we) begin
                        w = rd_word(mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                        dmem[mem_addr] = w;
                    end
                    txq.push_back('{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata});
                    wcnt = 0;
                    prev_wait = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                    prev_wait = 1'b1;
                    h_addr = mem_addr; h_be = mem_be; h_wd = mem_wdata; h_we = mem_we;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
                prev_wait = 1'b0;
            end
        end
    end

    // ---------------- request driver ----------------
    typedef struct {
        logic [31:0] ld;
        logic        err;
        int          lat;
        logic        stall0;
        logic        dstall;
        logic        dmreq;
        logic        mreq_prev;
        logic        extra;
    } res_t;

    task automatic do_req(input logic w, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, output res_t r);
        logic pm;
        r = '{ld: 32'h0, err: 1'b0, lat: -1, stall0: 1'b0, dstall: 1'b0,
              dmreq: 1'b0, mreq_prev: 1'b0, extra: 1'b0};
        @(posedge clk);
        #1;
        txq.delete();
        we = w; ls_op = op; addr = a; st_data = d; req = 1'b1;
        #1 r.stall0 = stall;
        @(posedge clk);
        #1 req = 1'b0;
        pm = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                r.lat = i; r.ld = ld_data; r.err = err;
                r.dstall = stall; r.dmreq = mem_req; r.mreq_prev = pm;
                break;
            end
            pm = mem_req;
        end
        @(negedge clk);
        r.extra = done;
    endtask

    task automatic run_txn(input logic w, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, output res_t r,
                           output logic [31:0] m_ld, output logic m_err, output int m_ntx);
        ref_access(w, op, a, d, m_ld, m_err, m_ntx);
        do_req(w, op, a, d, r);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] exp_ld;
        logic        exp_err;
        int          exp_ntx;
        int          exp_lat;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        logic [31:0] m_ld;
        logic m_err;
        int m_ntx;
        int cnt;
        logic seen;

        rst_n = 1'b0; req = 1'b0; req2 = 1'b0; ack2 = 1'b0;
        we = 1'b0; ls_op = 3'b000; addr = 32'h0; st_data = 32'h0;

        // reset state
        #3;
        check32("rst_stall", {31'h0, stall}, 0);
        check32("rst_done", {31'h0, done}, 0);
        check32("rst_err", {31'h0, err}, 0);
        check32("rst_ld", ld_data, 0);
        check32("rst_mreq", {31'h0, mem_req}, 0);
        check32("rst_mwe", {31'h0, mem_we}, 0);
        check32("rst_maddr", mem_addr, 0);
        check32("rst_mbe", {28'h0, mem_be}, 0);
        check32("rst_mwdata", mem_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        preload(32'h100, 32'hDEAD_BEEF);
        preload(32'h110, 32'h8012_3456);
        preload(32'h000, 32'h1122_3344);
        preload(32'h004, 32'h5566_7788);

        //          we    op      addr          data          lat exp_ld        err  ntx lat
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,          2, 32'hDEAD_BEEF, 1'b0, 1, 4};
        tbl[1]  = '{1'b0, 3'b000, 32'h113, 32'h0,          0, 32'hFFFF_FF80, 1'b0, 1, 2};
        tbl[2]  = '{1'b0, 3'b100, 32'h113, 32'h0,          1, 32'h0000_0080, 1'b0, 1, 3};
        tbl[3]  = '{1'b0, 3'b001, 32'h112, 32'h0,          0, 32'hFFFF_8012, 1'b0, 1, 2};
        tbl[4]  = '{1'b0, 3'b101, 32'h112, 32'h0,          0, 32'h0000_8012, 1'b0, 1, 2};
        tbl[5]  = '{1'b0, 3'b010, 32'h002, 32'h0,          0, 32'h7788_1122, 1'b0, 2, 3};
        tbl[6]  = '{1'b0, 3'b011, 32'h100, 32'h0,          0, 32'h0,         1'b1, 0, 1};
        tbl[7]  = '{1'b1, 3'b100, 32'h100, 32'h55,         0, 32'h0,         1'b1, 0, 1};
        tbl[8]  = '{1'b1, 3'b010, 32'h120, 32'hCAFE_F00D,  1, 32'h0,         1'b0, 1, 3};
        tbl[9]  = '{1'b0, 3'b010, 32'h120, 32'h0,          0, 32'hCAFE_F00D, 1'b0, 1, 2};
        tbl[10] = '{1'b1, 3'b000, 32'h131, 32'h1234_56A5,  0, 32'h0,         1'b0, 1, 2};
        tbl[11] = '{1'b0, 3'b100, 32'h131, 32'h0,          0, 32'h0000_00A5, 1'b0, 1, 2};
        tbl[12] = '{1'b0, 3'b111, 32'h100, 32'h0,          0, 32'h0,         1'b1, 0, 1};
        tbl[13] = '{1'b0, 3'b001, 32'h101, 32'h0,          0, 32'hFFFF_ADBE, 1'b0, 1, 2};
        tbl[14] = '{1'b0, 3'b110, 32'h100, 32'h0,          0, 32'h0,         1'b1, 0, 1};

        for (int i = 0; i < 15; i++) begin
            lat = tbl[i].lat;
            run_txn(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].data, r, m_ld, m_err, m_ntx);
            check32($sformatf("v%0d_ld", i), r.ld, tbl[i].exp_ld);
            check32($sformatf("v%0d_err", i), {31'h0, r.err}, {31'h0, tbl[i].exp_err});
            check32($sformatf("v%0d_ntx", i), txq.size(), tbl[i].exp_ntx);
            check32($sformatf("v%0d_lat", i), r.lat, tbl[i].exp_lat);
            check32($sformatf("v%0d_stall0", i), {31'h0, r.stall0}, 1);
            check32($sformatf("v%0d_dstall", i), {31'h0, r.dstall}, 0);
            check32($sformatf("v%0d_once", i), {31'h0, r.extra}, 0);
        end

        // split store: SH at 0x203
        lat = 0;
        run_txn(1'b1, 3'b001, 32'h203, 32'h0000_ABCD, r, m_ld, m_err, m_ntx);
        check32("sh_err", {31'h0, r.err}, 0);
        check32("sh_lat", r.lat, 3);
        check32("sh_once", {31'h0, r.extra}, 0);
        check32("sh_ntx", txq.size(), 2);
        if (txq.size() == 2) begin
            check32("sh_a0", txq[0].addr, 32'h200);
            check32("sh_be0", {28'h0, txq[0].be}, 32'h8);
            check32("sh_wd0", {24'h0, txq[0].wdata[31:24]}, 32'hCD);
            check32("sh_we0", {31'h0, txq[0].we}, 1);
            check32("sh_a1", txq[1].addr, 32'h204);
            check32("sh_be1", {28'h0, txq[1].be}, 32'h1);
            check32("sh_wd1", {24'h0, txq[1].wdata[7:0]}, 32'hAB);
        end
        run_txn(1'b0, 3'b101, 32'h203, 32'h0, r, m_ld, m_err, m_ntx);
        check32("sh_rd", r.ld, 32'h0000_ABCD);

        // ack timeout
        lat = 255;
        run_txn(1'b0, 3'b010, 32'h140, 32'h0, r, m_ld, m_err, m_ntx);
        check32("to_lat", r.lat, 17);
        check32("to_err", {31'h0, r.err}, 1);
        check32("to_ld", r.ld, 0);
        check32("to_req_before", {31'h0, r.mreq_prev}, 1);
        check32("to_req_drop", {31'h0, r.dmreq}, 0);
        check32("to_ntx", txq.size(), 0);

        // reset in the middle of ACC0
        @(posedge clk);
        #1 we = 1'b0; ls_op = 3'b010; addr = 32'h150; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check32("mid_req_up", {31'h0, mem_req}, 1);
        #2 rst_n = 1'b0;
        #1;
        check32("mid_req_drop", {31'h0, mem_req}, 0);
        check32("mid_stall_drop", {31'h0, stall}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check32("mid_no_done", cnt, 0);
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, r, m_ld, m_err, m_ntx);
        check32("mid_recover", r.ld, 32'hDEAD_BEEF);

        // no-split instance: crossing access errors without touching memory
        @(posedge clk);
        #1 we = 1'b0; ls_op = 3'b010; addr = 32'h002; req2 = 1'b1;
        seen = mem_req2;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(negedge clk);
        seen = seen | mem_req2;
        check32("ns_done", {31'h0, done2}, 1);
        check32("ns_err", {31'h0, err2}, 1);
        @(negedge clk);
        seen = seen | mem_req2;
        check32("ns_noreq", {31'h0, seen}, 0);
        // aligned access on the same instance still reaches memory (no ack -> timeout)
        @(posedge clk);
        #1 addr = 32'h100; req2 = 1'b1;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(negedge clk);
        check32("ns_aligned_req", {31'h0, mem_req2}, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done2) begin cnt = 1; break; end
        end
        check32("ns_to_done", cnt, 1);
        check32("ns_to_err", {31'h0, err2}, 1);

        // randomized traffic against the byte-level model
        for (int k = 0; k < 200; k++) begin
            logic        rw;
            logic [2:0]  rop;
            logic [31:0] ra, rd;
            rw  = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'h100 + 32'($urandom_range(0, 63));
            rd  = $urandom;
            lat = $urandom_range(0, 3);
            run_txn(rw, rop, ra, rd, r, m_ld, m_err, m_ntx);
            check32($sformatf("rnd%0d_ld a=%h op=%0d we=%0d", k, ra, rop, rw), r.ld, m_ld);
            check32($sformatf("rnd%0d_err", k), {31'h0, r.err}, {31'h0, m_err});
            check32($sformatf("rnd%0d_ntx", k), txq.size(), m_ntx);
            check32($sformatf("rnd%0d_once", k), {31'h0, r.extra}, 0);
        end

        check32("hold_stable", hold_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
